chacha_block_sched: RTL and testbench
=====================================

// Module: chacha_block_sched
// PURPOSE
//  Sequences the ChaCha keystream core for one message: loads the initial block counter,
//  issues one core start per 64-byte block, and presents each finished keystream block
//  downstream on a valid/ready handshake.
//  Sits between the message-auth top-level control and the ChaCha core.
//  Owns the 32-bit block counter and flags counter wrap-around as an error.
// PARAMETERS
//  CNTR_WIDTH  32   block counter width (RFC 8439 counter)
//  NBLK_WIDTH  16   width of the requested block count
//  BLK_WIDTH   512  keystream block width
// PORTS
//  clk           in   1           clock
//  resetn        in   1           reset, asynchronous, active-high
//  start         in   1           begin message; sampled only in IDLE
//  init_counter  in   CNTR_WIDTH  first block counter value, sampled with start
//  num_blocks    in   NBLK_WIDTH  blocks to generate, sampled with start
//  abort         in   1           cancel current message
//  busy          out  1           high in any state except IDLE
//  done          out  1           1-cycle pulse: all blocks handed off
//  err_wrap      out  1           sticky: counter would wrap past all-ones
//  core_start    out  1           1-cycle pulse to the ChaCha core
//  core_counter  out  CNTR_WIDTH  counter for the current block; stable from core_start to core_done
//  core_done     in   1           core finished; core_block valid this cycle
//  core_block    in   BLK_WIDTH   keystream block from the core
//  ks_valid      out  1           ks_data valid
//  ks_ready      in   1           downstream accepts
//  ks_data       out  BLK_WIDTH   registered keystream block
//  ks_last       out  1           qualifies the final block of the message (with ks_valid)
//  blocks_left   out  NBLK_WIDTH  blocks not yet accepted downstream
// BEHAVIOUR
//  Reset: state = IDLE; all outputs = 0.
//  FSM states: IDLE, ISSUE, WAIT, OUT, ERR.
//  - IDLE:
//    - start && num_blocks != 0: load counter = init_counter, blocks_left = num_blocks,
//      clear err_wrap; go to ISSUE.
//    - start && num_blocks == 0: done pulses on the next cycle; stay in IDLE; no core_start.
//  - ISSUE: core_start = 1 for exactly one cycle; go to WAIT.
//  - WAIT: on core_done, register core_block into ks_data and set ks_valid = 1;
//    ks_last = (blocks_left == 1); go to OUT.
//  - OUT: ks_data and ks_last hold while ks_valid && !ks_ready. On handshake:
//    - blocks_left -= 1.
//    - If this was the last block: done pulses the next cycle; go to IDLE.
//    - Else if counter == all-ones: set err_wrap; go to ERR; no further core_start.
//    - Else counter += 1; go to ISSUE (core_start lands 1 cycle after the handshake).
//  - ERR: one cycle, then IDLE with done = 0. err_wrap stays high until the next accepted start.
//  Timing and boundary rules:
//  - Min per-block latency: core_start -> core latency -> ks_valid 1 cycle after core_done.
//  - Only one block is in flight; no core_start is issued while ks_valid is high.
//  - core_done outside WAIT is ignored, including a stray done after abort.
//  - start while busy is ignored.
//  - abort (any non-IDLE state) -> IDLE next cycle; ks_valid drops; no done; err_wrap unchanged.
//    abort has priority over a simultaneous core_done or ks handshake.
//  - Async reset mid-message returns immediately to the reset state.
//  - Counter arithmetic is modulo 2^CNTR_WIDTH, but the increment from all-ones is never taken (ERR instead).
// STRUCTURE
//  - Package chacha_sched_pkg: state_t enum {IDLE, ISSUE, WAIT, OUT, ERR}; BLK_WIDTH and
//    CNTR_WIDTH defaults as localparams.
//  - Sub-module: the shared `counter` (CNTR_WIDTH) drives core_counter:
//    - enable = load | incr; force_bit = load; force_value = init_counter.
//  - blocks_left down-counter, FSM and ks_data register are local.
// TESTING
//  1. init_counter=1, num_blocks=3, core_done 4 cycles after core_start, ks_ready=1
//     -> core_counter 1,2,3; 3 ks beats; ks_last on beat 3 only; one done pulse; busy falls.
//  2. Same as 1 but ks_ready low 5 cycles on beat 1
//     -> ks_data/ks_last stable; no core_start until 1 cycle after the handshake.
//  3. init_counter=32'hFFFF_FFFE, num_blocks=3
//     -> blocks with counters FFFF_FFFE and FFFF_FFFF; err_wrap=1; no third core_start;
//        no done; blocks_left=1.
//  4. num_blocks=0 -> done pulse 1 cycle after start; core_start never asserted.
//  5. abort in WAIT, then core_done 2 cycles later
//     -> IDLE, ks_valid=0, done=0; the late core_done is ignored;
//        a fresh start (init_counter=7, num_blocks=1) completes normally.
//  6. resetn asserted in OUT with ks_valid=1 -> all outputs 0 immediately; FSM = IDLE.

Source files
------------

// File: rtl/chacha_sched_pkg.sv
// Shared types and default widths for the ChaCha block scheduler.
package chacha_sched_pkg;

    localparam int unsigned DEF_CNTR_WIDTH = 32;
    localparam int unsigned DEF_NBLK_WIDTH = 16;
    localparam int unsigned DEF_BLK_WIDTH  = 512;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/counter.sv
// Loadable up-counter: force_bit loads force_value, otherwise enable increments modulo 2^WIDTH.
module counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_enable,
    input  logic             i_force_bit,
    input  logic [WIDTH-1:0] i_force_value,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= i_force_bit ? i_force_value : r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/chacha_block_sched.sv
// Per-message ChaCha keystream sequencer: one core run per 64-byte block,
// each finished block handed downstream on a valid/ready port.
module chacha_block_sched
    import chacha_sched_pkg::*;
#(
    parameter int unsigned CNTR_WIDTH = DEF_CNTR_WIDTH,
    parameter int unsigned NBLK_WIDTH = DEF_NBLK_WIDTH,
    parameter int unsigned BLK_WIDTH  = DEF_BLK_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [CNTR_WIDTH-1:0] init_counter,
    input  logic [NBLK_WIDTH-1:0] num_blocks,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err_wrap,
    output logic                  core_start,
    output logic [CNTR_WIDTH-1:0] core_counter,
    input  logic                  core_done,
    input  logic [BLK_WIDTH-1:0]  core_block,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic [BLK_WIDTH-1:0]  ks_data,
    output logic                  ks_last,
    output logic [NBLK_WIDTH-1:0] blocks_left
);

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_busy;
    logic                  r_done;
    logic                  r_err_wrap;
    logic                  r_core_start;
    logic                  r_ks_valid;
    logic                  r_ks_last;
    logic [BLK_WIDTH-1:0]  r_ks_data;
    logic [NBLK_WIDTH-1:0] r_blocks_left;

    logic                  w_abort;
    logic                  w_hs;
    logic                  w_load;
    logic                  w_incr;
    logic                  w_capture;
    logic                  w_dec;
    logic                  w_done_set;
    logic                  w_err_set;
    logic                  w_ctr_max;
    logic [CNTR_WIDTH-1:0] w_counter;

    assign w_abort   = abort && (r_state != IDLE);
    assign w_hs      = (r_state == OUT) && r_ks_valid && ks_ready;
    assign w_ctr_max = &w_counter;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort overrides every other transition out of a busy state.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start && (num_blocks != '0)) w_state_nxt = ISSUE;
                ISSUE:   w_state_nxt = WAIT;
                WAIT:    if (core_done) w_state_nxt = OUT;
                OUT: begin
                    if (w_hs) begin
                        if (r_ks_last)      w_state_nxt = IDLE;
                        else if (w_ctr_max) w_state_nxt = ERR;
                        else                w_state_nxt = ISSUE;
                    end
                end
                ERR:     w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_load     = 1'b0;
        w_incr     = 1'b0;
        w_capture  = 1'b0;
        w_dec      = 1'b0;
        w_done_set = 1'b0;
        w_err_set  = 1'b0;
        if (!w_abort) begin
            case (r_state)
                IDLE: begin
                    w_load     = start && (num_blocks != '0);
                    w_done_set = start && (num_blocks == '0);
                end
                WAIT:    w_capture = core_done;
                OUT: begin
                    if (w_hs) begin
                        w_dec = 1'b1;
                        if (r_ks_last)      w_done_set = 1'b1;
                        else if (w_ctr_max) w_err_set  = 1'b1;
                        else                w_incr     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status and keystream registers; busy/core_start track the next state so they align with it.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_wrap    <= 1'b0;
            r_core_start  <= 1'b0;
            r_ks_valid    <= 1'b0;
            r_ks_last     <= 1'b0;
            r_ks_data     <= '0;
            r_blocks_left <= '0;
        end else begin
            r_busy       <= (w_state_nxt != IDLE);
            r_core_start <= (w_state_nxt == ISSUE);
            r_done       <= w_done_set;

            if (w_load)         r_err_wrap <= 1'b0;
            else if (w_err_set) r_err_wrap <= 1'b1;

            if (w_load)     r_blocks_left <= num_blocks;
            else if (w_dec) r_blocks_left <= r_blocks_left - NBLK_WIDTH'(1);

            if (w_capture) begin
                r_ks_valid <= 1'b1;
                r_ks_data  <= core_block;
                r_ks_last  <= (r_blocks_left == NBLK_WIDTH'(1));
            end else if (w_abort || w_hs) begin
                r_ks_valid <= 1'b0;
                r_ks_last  <= 1'b0;
            end
        end
    end

    counter #(
        .WIDTH(CNTR_WIDTH)
    ) u_counter (
        .clk          (clk),
        .resetn       (resetn),
        .i_enable     (w_load | w_incr),
        .i_force_bit  (w_load),
        .i_force_value(init_counter),
        .o_count      (w_counter)
    );

    assign busy         = r_busy;
    assign done         = r_done;
    assign err_wrap     = r_err_wrap;
    assign core_start   = r_core_start;
    assign core_counter = w_counter;
    assign ks_valid     = r_ks_valid;
    assign ks_last      = r_ks_last;
    assign ks_data      = r_ks_data;
    assign blocks_left  = r_blocks_left;

endmodule

// File: tb/tb_chacha_block_sched.sv
// Scoreboard bench for chacha_block_sched with a fixed-latency ChaCha core model.
module tb_chacha_block_sched;

    localparam int unsigned CW       = 32;
    localparam int unsigned NW       = 16;
    localparam int unsigned BW       = 512;
    localparam int unsigned CORE_LAT = 4;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
    } exp_blk_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [CW-1:0] init_counter;
    logic [NW-1:0] num_blocks;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err_wrap;
    logic          core_start;
    logic [CW-1:0] core_counter;
    logic          core_done = 1'b0;
    logic [BW-1:0] core_block = '0;
    logic          ks_valid;
    logic          ks_ready;
    logic [BW-1:0] ks_data;
    logic          ks_last;
    logic [NW-1:0] blocks_left;

    logic [CW-1:0] exp_ctr_q[$];
    exp_blk_t      exp_blk_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int cs_cnt   = 0;

    chacha_block_sched dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .init_counter(init_counter),
        .num_blocks  (num_blocks),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err_wrap    (err_wrap),
        .core_start  (core_start),
        .core_counter(core_counter),
        .core_done   (core_done),
        .core_block  (core_block),
        .ks_valid    (ks_valid),
        .ks_ready    (ks_ready),
        .ks_data     (ks_data),
        .ks_last     (ks_last),
        .blocks_left (blocks_left)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] blk_of(input logic [CW-1:0] c);
        logic [BW-1:0] b;
        for (int i = 0; i < 16; i++) begin
            b[i*32 +: 32] = c ^ 32'(32'h9E37_79B9 * 32'(i + 1));
        end
        return b;
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Core model: answers each core_start with core_done CORE_LAT cycles later.
    logic          m_pend = 1'b0;
    int            m_cnt  = 0;
    logic [CW-1:0] m_ctr  = '0;
    always @(negedge clk) begin
        core_done = 1'b0;
        if (m_pend) begin
            if (m_cnt == 1) begin
                core_done  = 1'b1;
                core_block = blk_of(m_ctr);
                m_pend     = 1'b0;
            end else begin
                m_cnt--;
            end
        end
        if (core_start && !resetn) begin
            m_pend = 1'b1;
            m_cnt  = CORE_LAT;
            m_ctr  = core_counter;
        end
    end

    // Output monitor: pops the scoreboard on core_start and on each ks handshake.
    always @(negedge clk) begin
        if (!resetn) begin
            if (done) done_cnt++;
            if (core_start) begin
                cs_cnt++;
                check("cs_while_valid", BW'(ks_valid), BW'(0));
                if (exp_ctr_q.size() == 0) begin
                    check("unexp_core_start", BW'(1), BW'(0));
                end else begin
                    check("core_counter", BW'(core_counter), BW'(exp_ctr_q.pop_front()));
                end
            end
            if (ks_valid && ks_ready) begin
                exp_blk_t e;
                beat_cnt++;
                if (exp_blk_q.size() == 0) begin
                    check("unexp_ks_beat", BW'(1), BW'(0));
                end else begin
                    e = exp_blk_q.pop_front();
                    check("ks_data", ks_data, e.data);
                    check("ks_last", BW'(ks_last), BW'(e.last));
                end
            end
        end
    end

    task automatic do_start(input logic [CW-1:0] ic, input logic [NW-1:0] nb);
        @(posedge clk); #1;
        start = 1'b1; init_counter = ic; num_blocks = nb;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_msg(input logic [CW-1:0] ic, input int nstart, input int nblk, input int total);
        for (int i = 0; i < nstart; i++) exp_ctr_q.push_back(ic + CW'(i));
        for (int i = 0; i < nblk; i++) begin
            exp_blk_t e;
            e.data = blk_of(ic + CW'(i));
            e.last = (i == total - 1);
            exp_blk_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int base, input string tag);
        int n = 0;
        while (done_cnt == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, BW'(done_cnt != base), BW'(1));
    endtask

    task automatic wait_ks_valid(input string tag);
        int n = 0;
        while (!ks_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, BW'(ks_valid), BW'(1));
    endtask

    initial begin
        int d0, b0, c0, n;
        logic seen_valid;
        resetn = 1'b1; start = 1'b0; init_counter = '0; num_blocks = '0;
        abort = 1'b0; ks_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", BW'(busy), BW'(0));
        check("rst_outs", BW'({done, err_wrap, core_start, ks_valid, ks_last}), BW'(0));
        check("rst_ctr", BW'(core_counter), BW'(0));
        @(negedge clk) resetn = 1'b0;

        // 1: three blocks, ready always high
        d0 = done_cnt; b0 = beat_cnt;
        push_msg(32'd1, 3, 3, 3);
        do_start(32'd1, 16'd3);
        @(negedge clk);
        check("t1_busy", BW'(busy), BW'(1));
        wait_done(d0, "t1_done_timeout");
        repeat (3) @(negedge clk);
        check("t1_done_once", BW'(done_cnt - d0), BW'(1));
        check("t1_beats", BW'(beat_cnt - b0), BW'(3));
        check("t1_busy_fall", BW'(busy), BW'(0));
        check("t1_q_empty", BW'(exp_ctr_q.size() + exp_blk_q.size()), BW'(0));
        check("t1_blocks_left", BW'(blocks_left), BW'(0));

        // 2: beat 1 back-pressured for 5 cycles
        d0 = done_cnt;
        ks_ready = 1'b0;
        push_msg(32'd1, 3, 3, 3);
        do_start(32'd1, 16'd3);
        wait_ks_valid("t2_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_data", ks_data, blk_of(32'd1));
            check("t2_hold_last", BW'(ks_last), BW'(0));
            check("t2_no_cs_stall", BW'(core_start), BW'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;
        ks_ready = 1'b1;
        @(negedge clk);
        check("t2_no_cs_in_hs", BW'(core_start), BW'(0));
        @(negedge clk);
        check("t2_cs_after_hs", BW'(core_start), BW'(1));
        check("t2_left_after_hs", BW'(blocks_left), BW'(2));
        wait_done(d0, "t2_done_timeout");
        check("t2_q_empty", BW'(exp_ctr_q.size() + exp_blk_q.size()), BW'(0));

        // 3: counter wrap -> ERR
        d0 = done_cnt; c0 = cs_cnt; b0 = beat_cnt;
        push_msg(32'hFFFF_FFFE, 2, 2, 3);
        do_start(32'hFFFF_FFFE, 16'd3);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t3_busy_timeout", BW'(busy), BW'(0));
        repeat (CORE_LAT + 2) @(negedge clk);
        check("t3_err_wrap", BW'(err_wrap), BW'(1));
        check("t3_no_done", BW'(done_cnt - d0), BW'(0));
        check("t3_starts", BW'(cs_cnt - c0), BW'(2));
        check("t3_beats", BW'(beat_cnt - b0), BW'(2));
        check("t3_blocks_left", BW'(blocks_left), BW'(1));
        check("t3_q_empty", BW'(exp_ctr_q.size() + exp_blk_q.size()), BW'(0));

        // 4: zero blocks
        c0 = cs_cnt;
        do_start(32'd5, 16'd0);
        @(negedge clk);
        check("t4_done_pulse", BW'(done), BW'(1));
        check("t4_busy", BW'(busy), BW'(0));
        @(negedge clk);
        check("t4_done_end", BW'(done), BW'(0));
        repeat (4) @(negedge clk);
        check("t4_no_cs", BW'(cs_cnt - c0), BW'(0));

        // 5: abort in WAIT with a stray core_done afterwards
        d0 = done_cnt; b0 = beat_cnt;
        push_msg(32'h20, 1, 0, 2);
        do_start(32'h20, 16'd2);
        @(negedge clk);
        check("t5_cs", BW'(core_start), BW'(1));
        check("t5_err_clr", BW'(err_wrap), BW'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("t5_abort_idle", BW'({busy, ks_valid, done}), BW'(0));
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen_valid |= ks_valid | busy;
        end
        check("t5_stray_ignored", BW'(seen_valid), BW'(0));
        check("t5_no_done", BW'(done_cnt - d0), BW'(0));
        push_msg(32'd7, 1, 1, 1);
        do_start(32'd7, 16'd1);
        wait_done(d0, "t5_fresh_timeout");
        check("t5_fresh_beats", BW'(beat_cnt - b0), BW'(1));
        check("t5_q_empty", BW'(exp_ctr_q.size() + exp_blk_q.size()), BW'(0));

        // 6: async reset while a block waits in OUT
        ks_ready = 1'b0;
        push_msg(32'h100, 1, 0, 2);
        do_start(32'h100, 16'd2);
        wait_ks_valid("t6_valid_timeout");
        #2 resetn = 1'b1;
        #1;
        check("t6_rst_status", BW'({busy, done, err_wrap, core_start, ks_valid, ks_last}), BW'(0));
        check("t6_rst_data", ks_data, BW'(0));
        check("t6_rst_ctr", BW'(core_counter), BW'(0));
        check("t6_rst_left", BW'(blocks_left), BW'(0));
        @(negedge clk);
        resetn = 1'b0;
        ks_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_idle_after", BW'({busy, ks_valid}), BW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
